bar_arbiter: RTL and testbench

BAR_ARBITER -- requirements
Module: bar_arbiter

---
 rtl/bar_arbiter_if.sv | 9 +
 rtl/bar_arbiter.sv | 152 +++++++++++++++
 tb/tb_bar_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bar_arbiter_if.sv
// rtl/bar_arbiter_if.sv - valid/ready stream bundle shared by requesters and the output port
interface bar;
   logic        valid;
   logic [31:0] data;
   logic        ready;

   modport src (output valid, output data, input ready);
   modport dst (input valid, input data, output ready);
endinterface

// File: rtl/bar_arbiter.sv
// rtl/bar_arbiter.sv - round-robin burst arbiter of N bar streams onto one output stream
// Optional per-requester transfer counters: define BAR_ARB_STATS_EN.
module bar_arbiter #(
   parameter int N         = 4,
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         rst,
   bar.dst              s [N],
   bar.src              m,
   output logic [N-1:0] gnt,
   output logic         busy
`ifdef BAR_ARB_STATS_EN
   ,
   output logic [N-1:0][15:0] xfer_cnt
`endif
);

   localparam int IW = $clog2(N);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [IW-1:0]   gidx_q, gidx_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [N-1:0]    s_valid;
   logic [31:0]     s_data [N];
   logic [N-1:0]    s_ready;
   logic            m_ready;
   logic            m_valid;
   logic [31:0]     m_data;
   logic            xfer;
   logic [N-1:0]    others;

   for (genvar i = 0; i < N; i++) begin : g_port
      assign s_valid[i] = s[i].valid;
      assign s_data[i]  = s[i].data;
      assign s[i].ready = s_ready[i];
   end

   assign m_ready = m.ready;
   assign m.valid = m_valid;
   assign m.data  = m_data;
   assign gnt     = grant_q;
   assign busy    = (state_q == GRANT);

   // First set bit of req scanning start, start+1, ... wrapping modulo N.
   function automatic logic [IW-1:0] pick(input logic [N-1:0] req, input logic [IW-1:0] start);
      logic [IW-1:0] res;
      logic          hit;
      res = '0;
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (int'(start) + k) % N;
         if (!hit && req[idx]) begin
            res = IW'(idx);
            hit = 1'b1;
         end
      end
      return res;
   endfunction

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
      return IW'((int'(x) + 1) % N);
   endfunction

   always_comb begin
      state_d = state_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      m_valid = 1'b0;
      m_data  = '0;
      s_ready = '0;
      xfer    = 1'b0;
      others  = s_valid & ~grant_q;

      case (state_q)
         IDLE: begin
            if (|s_valid) begin
               state_d = GRANT;
               gidx_d  = pick(s_valid, ptr_q);
               ptr_d   = next_idx(gidx_d);
               cnt_d   = '0;
            end
         end
         GRANT: begin
            m_valid         = s_valid[gidx_q];
            m_data          = s_data[gidx_q];
            s_ready[gidx_q] = m_ready;
            xfer            = m_valid & m_ready;
            // ptr_q already holds gidx+1, so scanning from it skips the current owner first.
            if ((xfer && cnt_q == CNT_LAST) || !m_valid) begin
               if (|others) begin
                  gidx_d = pick(others, ptr_q);
                  ptr_d  = next_idx(gidx_d);
                  cnt_d  = '0;
               end else if (xfer) begin
                  cnt_d = '0;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end else if (xfer) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      grant_d = (state_d == GRANT) ? ({{(N-1){1'b0}}, 1'b1} << gidx_d) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef BAR_ARB_STATS_EN
   logic [N-1:0][15:0] xfer_cnt_q;

   assign xfer_cnt = xfer_cnt_q;

   for (genvar i = 0; i < N; i++) begin : g_stats
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            xfer_cnt_q[i] <= '0;
         end else if (s_ready[i] && s_valid[i] && xfer_cnt_q[i] != 16'hFFFF) begin
            xfer_cnt_q[i] <= xfer_cnt_q[i] + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bar_arbiter.sv
// tb/tb_bar_arbiter.sv - randomized and directed check of bar_arbiter against a behavioural model
module tb_bar_arbiter;
   localparam int N  = 4;
   localparam int MB = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    tb_valid;
   logic [31:0]     tb_data [N];
   logic [N-1:0]    tb_ready;
   logic            tb_mready;
   logic [N-1:0]    gnt;
   logic            busy;
`ifdef BAR_ARB_STATS_EN
   logic [N-1:0][15:0] xfer_cnt;
`endif

   bar s_if [N] ();
   bar m_if ();

   always #5 clk = ~clk;

   for (genvar i = 0; i < N; i++) begin : g_s
      assign s_if[i].valid = tb_valid[i];
      assign s_if[i].data  = tb_data[i];
      assign tb_ready[i]   = s_if[i].ready;
   end
   assign m_if.ready = tb_mready;

   bar_arbiter #(.N(N), .MAX_BURST(MB)) dut (
      .clk  (clk),
      .rst  (rst),
      .s    (s_if),
      .m    (m_if),
      .gnt  (gnt),
      .busy (busy)
`ifdef BAR_ARB_STATS_EN
      ,
      .xfer_cnt (xfer_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Model state: owner index (-1 when idle), transfers in this burst, search start.
   int cur, cnt, ptr;
   int seq  [N];
   int scnt [N];
   int dlog [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void set_data(input int i);
      tb_data[i] = {8'(i), 8'hA5, 16'(seq[i])};
   endfunction

   function automatic int first_from(input int start, input int excl);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (start + k) % N;
         if (tb_valid[idx] && idx != excl) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      cur = -1;
      cnt = 0;
      ptr = 0;
      for (int i = 0; i < N; i++) scnt[i] = 0;
   endtask

   // Check outputs mid-cycle, log the observed transfer, advance model across the edge.
   task automatic step();
      int o, xf, src;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      exp_rdy = (cur >= 0 && tb_mready) ? (N'(1) << cur) : '0;
      check("m_valid", m_if.valid, (cur >= 0) ? tb_valid[cur] : 1'b0);
      check("m_data",  m_if.data,  (cur >= 0) ? tb_data[cur] : 32'd0);
      check("ready",   tb_ready,   exp_rdy);
      check("gnt",     gnt,        (cur >= 0) ? (N'(1) << cur) : '0);
      check("busy",    busy,       cur >= 0);
`ifdef BAR_ARB_STATS_EN
      for (int i = 0; i < N; i++) check("xfer_cnt", xfer_cnt[i], scnt[i]);
`endif
      if (m_if.valid && tb_mready) begin
         src = -1;
         for (int i = 0; i < N; i++) if (tb_ready[i]) src = i;
         dlog.push_back(src);
      end
      xf = -1;
      if (cur < 0) begin
         o = first_from(ptr, -1);
         if (o >= 0) begin
            cur = o; cnt = 0; ptr = (o + 1) % N;
         end
      end else if (tb_valid[cur] && tb_mready) begin
         xf = cur;
         cnt++;
         if (cnt == MB) begin
            cnt = 0;
            o = first_from(cur + 1, cur);
            if (o >= 0) begin
               cur = o; ptr = (o + 1) % N;
            end
         end
      end else if (!tb_valid[cur]) begin
         o = first_from(cur + 1, cur);
         cnt = 0;
         if (o >= 0) begin
            cur = o; ptr = (o + 1) % N;
         end else begin
            cur = -1;
         end
      end
      @(posedge clk);
      #1;
      if (xf >= 0) begin
         seq[xf]++;
         set_data(xf);
         if (scnt[xf] < 65535) scnt[xf]++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tb_valid  = '0;
      tb_mready = 1'b0;
      @(posedge clk);
      #1;
      check("rst_m_valid", m_if.valid, 0);
      check("rst_m_data",  m_if.data,  0);
      check("rst_gnt",     gnt,        0);
      check("rst_busy",    busy,       0);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int exp_ord [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      int c;
      for (int i = 0; i < N; i++) begin
         seq[i] = 0;
         set_data(i);
      end
      model_reset();
      do_reset();

      // Single requester, five back-to-back words
      tb_valid[2] = 1'b1;
      tb_mready   = 1'b1;
      dlog.delete();
      step();
      check("req027_latency", m_if.valid, 1);
      for (c = 0; c < 50 && dlog.size() < 5; c++) begin
         step();
         if (dlog.size() == 5) tb_valid[2] = 1'b0;
      end
      check("req027_words", dlog.size(), 5);
      check("req027_b2b", c, 5);
      step();
      check("req027_idle", busy, 0);

      // All valid: burst-of-two rotation with no bubble
      do_reset();
      tb_valid  = '1;
      tb_mready = 1'b1;
      dlog.delete();
      for (c = 0; c < 40 && dlog.size() < 10; c++) step();
      check("req028_cycles", c, 11);
      for (int k = 0; k < 10; k++)
         check("req028_order", (k < dlog.size()) ? dlog[k] : -1, exp_ord[k]);

      // Backpressure on s[1] while s[3] waits
      do_reset();
      tb_valid[1] = 1'b1;
      tb_mready   = 1'b1;
      step();
      tb_mready   = 1'b0;
      tb_valid[3] = 1'b1;
      dlog.delete();
      for (int k = 0; k < 3; k++) step();
      check("req029_hold_gnt", gnt, 4'b0010);
      check("req029_hold_data", m_if.data, tb_data[1]);
      tb_mready = 1'b1;
      step();
      check("req029_done", (dlog.size() == 1) ? dlog[0] : -1, 1);

      // Owner drops before its first transfer
      do_reset();
      tb_valid[0] = 1'b1;
      step();
      tb_valid[0] = 1'b0;
      tb_valid[2] = 1'b1;
      tb_mready   = 1'b1;
      step();
      check("req030_move", gnt, 4'b0100);
      for (int k = 0; k < 4; k++) step();

      // Asynchronous reset mid-burst
      do_reset();
      tb_valid[1] = 1'b1;
      tb_mready   = 1'b1;
      step();
      step();
      check("req031_pre", m_if.valid, 1);
      rst = 1'b1;
      #1;
      check("req031_m_valid", m_if.valid, 0);
      check("req031_gnt",     gnt,        0);
      check("req031_ready",   tb_ready,   0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      tb_valid = '1;
      step();
      check("req031_restart", gnt, 4'b0001);
      step();

      // Random valid/ready traffic
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N; i++) tb_valid[i] = ($urandom_range(0, 9) < 6);
         tb_mready = ($urandom_range(0, 3) != 0);
         step();
      end

`ifdef BAR_ARB_STATS_EN
      do_reset();
      tb_valid[0] = 1'b1;
      tb_mready   = 1'b1;
      for (int k = 0; k < 70001; k++) step();
      check("req032_sat", xfer_cnt[0], 16'hFFFF);
      for (int i = 1; i < N; i++) check("req032_other", xfer_cnt[i], 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
